alu_hazard_ctrl: RTL
====================

Name: alu_hazard_ctrl

Overview:
- Forwarding and hazard controller for the EX-stage ALU of the 5-stage pipeline.
- Tracks destination-register tags of in-flight instructions in its own EX/MEM/WB shadow pipeline.
- Produces registered operand-select codes for the ALU input muxes, plus stall, bubble and flush controls for the pipeline registers.
- Handles RAW forwarding, load-use stalls and taken-branch flushes.

Parameters:
REG_AW, 5, register-address width
ZERO_REG, 0, hard-wired zero register index (never forwarded)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  valid instruction in ID
id_rs1  in  REG_AW  source 1 address
id_rs2  in  REG_AW  source 2 address
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_use_imm  in  1  ALU operand B is the immediate
id_rd  in  REG_AW  destination address
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
ex_branch_taken  in  1  branch in EX resolved taken (from ALU zero + branch decode)
sel_a_ex  out  2  ALU A select: 00 regfile, 01 EX/MEM ALU result, 10 WB write data
sel_b_ex  out  2  ALU B select: 00 regfile, 01 EX/MEM, 10 WB, 11 immediate
stall  out  1  hold PC and IF/ID register
bubble_ex  out  1  load a NOP into ID/EX
flush_if_id  out  1  clear IF/ID register
flush_id_ex  out  1  clear ID/EX register

Behaviour:
- Decisions:
  - All decisions are made in ID and registered on the ID→EX edge, so sel_*_ex is valid for the whole EX cycle of its instruction.
  - stall, bubble_ex, flush_* are combinational, for the current cycle.
- Shadow tags: ex_t, mem_t, wb_t, each holding {valid, rd, reg_write, mem_read}.
  - Every cycle: wb_t<=mem_t; mem_t<=ex_t.
  - ex_t<=ID fields, or invalid when bubbling or flushing.
- Match definition: a tag matches rsN only if all of the following hold:
  - tag valid
  - reg_write set
  - rd == rsN
  - rsN != ZERO_REG
  - id_uses_rsN set
- Forward selection for the instruction leaving ID:
  - ex_t match → 01 (the producer will be in MEM next cycle).
  - else mem_t match → 10 (the producer will be in WB).
  - else 00.
  - EX-stage match has priority over MEM-stage match.
  - sel_b forced to 11 when id_use_imm, regardless of matches.
- Load-use hazard: id_valid AND ex_t.mem_read AND ex_t matches rs1 or rs2 (the rs2 case only when !id_use_imm).
  - stall=1, bubble_ex=1 for exactly one cycle.
  - The next cycle re-evaluates; the producer is now in mem_t and forwards as 10.
- Taken branch: ex_branch_taken=1 → flush_if_id=1, flush_id_ex=1 that cycle; ex_t is loaded invalid.
  - Flush overrides load-use: stall=0 and bubble_ex=0 when a flush is asserted.
- Registered select values:
  - On bubble or flush, sel_a_ex/sel_b_ex load 00.
  - On !id_valid they also load 00 and ex_t loads invalid.
- Reset (async, immediate):
  - All tags invalid; sel_a_ex=00, sel_b_ex=00.
  - stall, bubble_ex, flush_* read 0 while rst is high.
  - Reset mid-stall abandons the stall; first post-reset cycle has no hazards.
- WB-stage tag is retained only for observability; the register file writes first-half / reads second-half, so no third forwarding level exists.
- Back-to-back loads to the same rd: the second load sees the first in ex_t and stalls normally.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 → second instr in EX: sel_a_ex=01, sel_b_ex=00, no stall.
- add x5; nop; or x7,x4,x5 → or in EX: sel_b_ex=10, sel_a_ex=00.
- lw x8,0(x1) then add x9,x8,x8 → one cycle stall=1, bubble_ex=1; then add in EX with sel_a_ex=10, sel_b_ex=10.
- add x0,x1,x2 then add x3,x0,x0 → sel_a_ex=00, sel_b_ex=00 (x0 not forwarded); addi x4,x5,imm after a writer of x5 → sel_b_ex=11, sel_a_ex=01.
- lw x8 in EX with load-use consumer in ID and ex_branch_taken=1 same cycle → flush_if_id=1, flush_id_ex=1, stall=0, bubble_ex=0; next-cycle ex_t invalid.
- Assert rst during a load-use stall → stall drops immediately; sel_*_ex=00; post-reset instruction reading the old rd gets 00.

Source files
------------

// File: rtl/alu_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// alu_hazard_ctrl
//   Forwarding and hazard controller for the EX-stage ALU of a 5-stage
//   pipeline. Keeps an EX/MEM/WB shadow pipeline of destination-register tags
//   for in-flight instructions. Forwarding decisions are made for the
//   instruction in ID and registered on the ID->EX edge, so the select codes
//   hold steady for that instruction's whole EX cycle. Stall, bubble and flush
//   controls are combinational and apply to the current cycle.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   id_valid          : valid instruction in ID
//   id_rs1, id_rs2    : source register addresses
//   id_uses_rs1/2     : instruction actually reads rs1 / rs2
//   id_use_imm        : ALU operand B is the immediate
//   id_rd             : destination register address
//   id_reg_write      : instruction writes rd
//   id_mem_read       : instruction is a load
//   ex_branch_taken   : branch in EX resolved taken
//   sel_a_ex          : ALU A select (00 regfile, 01 EX/MEM, 10 WB)
//   sel_b_ex          : ALU B select (00 regfile, 01 EX/MEM, 10 WB, 11 imm)
//   stall             : hold PC and IF/ID
//   bubble_ex         : load a NOP into ID/EX
//   flush_if_id       : clear IF/ID
//   flush_id_ex       : clear ID/EX
// -----------------------------------------------------------------------------
module alu_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic [1:0]        sel_a_ex,
  output logic [1:0]        sel_b_ex,
  output logic              stall,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } tag_t;

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_WB    = 2'b10,
    SEL_IMM   = 2'b11
  } sel_t;

  tag_t ex_t, mem_t, wb_t;
  tag_t ex_next;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic load_use, flush, hold, issue;
  sel_t fwd_a, fwd_b;

  // A producer tag can only feed a source that is really read and is not the
  // hard-wired zero register.
  function automatic logic tag_match(input tag_t t, input logic [REG_AW-1:0] rs,
                                     input logic uses);
    return t.valid && t.reg_write && (t.rd == rs) && (rs != ZERO_ADDR) && uses;
  endfunction

  always_comb begin
    ex_m1  = tag_match(ex_t,  id_rs1, id_uses_rs1);
    ex_m2  = tag_match(ex_t,  id_rs2, id_uses_rs2);
    mem_m1 = tag_match(mem_t, id_rs1, id_uses_rs1);
    mem_m2 = tag_match(mem_t, id_rs2, id_uses_rs2);
  end

  // Forward selection; the EX-stage producer is the most recent writer and
  // wins over the MEM-stage one.
  always_comb begin
    fwd_a = SEL_RF;
    if (ex_m1)       fwd_a = SEL_EXMEM;
    else if (mem_m1) fwd_a = SEL_WB;

    fwd_b = SEL_RF;
    if (id_use_imm)  fwd_b = SEL_IMM;
    else if (ex_m2)  fwd_b = SEL_EXMEM;
    else if (mem_m2) fwd_b = SEL_WB;
  end

  // Hazard and flush controls. A taken branch kills the ID instruction, so a
  // load-use hazard seen at the same time is irrelevant and must not stall.
  always_comb begin
    load_use = id_valid && ex_t.mem_read && (ex_m1 || (ex_m2 && !id_use_imm));
    flush    = ex_branch_taken && !rst;
    hold     = load_use && !flush && !rst;
    issue    = id_valid && !hold && !flush;

    ex_next = '0;
    if (issue) begin
      ex_next.valid     = 1'b1;
      ex_next.rd        = id_rd;
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
    end
  end

  assign stall       = hold;
  assign bubble_ex   = hold;
  assign flush_if_id = flush;
  assign flush_id_ex = flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_t     <= '0;
      mem_t    <= '0;
      wb_t     <= '0;
      sel_a_ex <= SEL_RF;
      sel_b_ex <= SEL_RF;
    end else begin
      wb_t  <= mem_t;
      mem_t <= ex_t;
      ex_t  <= ex_next;
      if (issue) begin
        sel_a_ex <= fwd_a;
        sel_b_ex <= fwd_b;
      end else begin
        sel_a_ex <= SEL_RF;
        sel_b_ex <= SEL_RF;
      end
    end
  end

  // The WB tag exists only for debug visibility: the register file writes in
  // the first half-cycle and reads in the second, so it never forwards.
  logic wb_tag_unused;
  assign wb_tag_unused = ^wb_t;

endmodule
